// File: rtl/regfile_mp.sv
// Two-read / two-write integer register file with load scoreboard and post-reset scrub.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            reset,
   output logic            init_done,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wa_en,
   input  logic [AW-1:0]   wa_addr,
   input  logic [XLEN-1:0] wa_data,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            busy_set,
   input  logic [AW-1:0]   busy_addr
);

`ifdef RF_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [NREGS-1:0]  busy_q, busy_d;
   logic [XLEN-1:0]   mem_q [NREGS];

   logic              run_w;
   logic [AW-1:0]     rd_addr_w [2];
   logic [XLEN-1:0]   rd_data_w [2];
   logic              rd_busy_w [2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_INIT;
         idx_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      case (state_q)
         S_INIT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = S_RUN;
               idx_d   = '0;
            end
         end
         S_RUN: begin
            // Set is applied after clear so a same-cycle set on the same entry wins.
            if (wb_en)
               busy_d[wb_addr] = 1'b0;
            if (busy_set)
               busy_d[busy_addr] = 1'b1;
         end
         default: state_d = S_INIT;
      endcase
      busy_d[0] = 1'b0;
   end

   // The array has no reset; the scrub walk clears it. Port A is written last so it wins a collision.
   always_ff @(posedge clk) begin
      if (state_q == S_INIT) begin
         mem_q[idx_q] <= '0;
      end else begin
         if (wb_en && wb_addr != '0)
            mem_q[wb_addr] <= wb_data;
         if (wa_en && wa_addr != '0)
            mem_q[wa_addr] <= wa_data;
      end
   end

   assign run_w        = (state_q == S_RUN);
   assign init_done    = run_w;
   assign rd_addr_w[0] = rs1_addr;
   assign rd_addr_w[1] = rs2_addr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data_w[p] = mem_q[rd_addr_w[p]];
         rd_busy_w[p] = busy_q[rd_addr_w[p]];
         if (BYPASS) begin
            if (wb_en && wb_addr == rd_addr_w[p]) begin
               rd_data_w[p] = wb_data;
               if (!(busy_set && busy_addr == rd_addr_w[p]))
                  rd_busy_w[p] = 1'b0;
            end
            if (wa_en && wa_addr == rd_addr_w[p])
               rd_data_w[p] = wa_data;
         end
         if (!run_w || rd_addr_w[p] == '0) begin
            rd_data_w[p] = '0;
            rd_busy_w[p] = 1'b0;
         end
      end
   end

   assign rs1_data = rd_data_w[0];
   assign rs2_data = rd_data_w[1];
   assign rs1_busy = rd_busy_w[0];
   assign rs2_busy = rd_busy_w[1];

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised integer register file for the RV32I core: two read ports, two write ports (port A: ALU/LUI/JAL writeback; port B: load writeback), a per-register load scoreboard and a post-reset scrub engine that clears the array one entry per cycle. It sits between decode (read addresses) and writeback, and replaces the single-port `lb`/`lui_cntrl`/`jump` priority file. The scrub engine means the array needs no async reset fan-out.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of 2, ≥ 2
- AW, 5, register address width; must equal log2(NREGS)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- init_done  out  1  high once scrub completes; file usable
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- rs1_busy, rs2_busy  out  1  source has an outstanding load
- wa_en  in  1  port A write enable
- wa_addr  in  AW  port A destination
- wa_data  in  XLEN  port A data
- wb_en  in  1  port B (load) write enable
- wb_addr  in  AW  port B destination
- wb_data  in  XLEN  port B data
- busy_set  in  1  load issued; mark busy_addr pending
- busy_addr  in  AW  destination of issued load

## Operation
- FSM states: INIT, RUN. Reset forces INIT, scrub index 0, busy vector 0, init_done 0.
- INIT: each cycle writes 0 to entry[index] and increments index. After entry NREGS-1 is written, go to RUN and set init_done. Reset mid-INIT restarts from index 0.
- In INIT: wa_en, wb_en and busy_set are ignored. rs*_data read 0 and rs*_busy read 0.
- RUN: writes commit at the rising edge. Reads are combinational from the array.
- Register 0: writes are discarded, busy_set is ignored, reads return 0, busy is always 0.
- Same-cycle write collision (wa_addr == wb_addr, both enabled): port A data is stored (port A is the younger instruction).
- Scoreboard: busy_set sets busy[busy_addr]; wb_en clears busy[wb_addr]. wa_en does not touch busy. If set and clear hit the same address in one cycle, set wins.
- Out-of-range addresses cannot occur (AW = log2(NREGS)).

## Timing
- Reset values: init_done 0, rs1_data/rs2_data 0, rs1_busy/rs2_busy 0.
- init_done rises NREGS rising edges after reset deasserts (32 by default).
- Write-to-read latency is 1 cycle without bypass, 0 cycles with bypass (see Configuration).
- Busy set/clear takes effect at the next edge. busy outputs are combinational from the busy vector (plus bypass, see Configuration).
- No backpressure: every enabled write in RUN is accepted.

## Configuration
- Macro: RF_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - rsN_data returns the write data when rsN_addr matches an enabled write this cycle. Port A has priority; register 0 still reads 0.
  - rsN_busy is forced 0 when wb_en && wb_addr == rsN_addr, unless busy_set targets that address in the same cycle.
- Undefined: reads return the stored array value and the registered busy bit only. The new value is visible the cycle after the write.

## Test plan
- Scrub: assert reset mid-INIT at cycle 10, release → init_done stays 0 for 32 edges, then 1. Read all 32 entries → each reads 0x00000000.
- Register 0: wa_en to addr 0 with 0xDEADBEEF, plus busy_set addr 0 → rs1_addr=0 reads 0, rs1_busy 0.
- Collision: wa and wb both to x7, data 0x11111111 (A) and 0x22222222 (B) → next cycle x7 reads 0x11111111.
- Scoreboard: busy_set x5 → rs1_busy 1 next cycle. Two cycles later wb_en x5 = 0x0800_0005 → busy clears and data 0x0800_0005 is readable. Same-cycle set+clear on x5 → busy stays 1.
- Bypass: read x8 while wa writes 0x0000000A to x8 → with RF_BYPASS_EN, rs2_data = 0x0000000A in the same cycle; without it, old value this cycle and 0x0000000A next cycle.
- Reset in RUN: with busy bits set and data written, assert reset → all outputs 0 immediately; full rescrub follows before init_done.
